// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: ALU and load FIFOs share one registered register-file write port.
// Define WB_RR_ARB_EN for round-robin tie-break; otherwise the load FIFO wins every tie.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_reg,
    input  logic [DATA_W-1:0] ld_data,
    output logic              regWrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] qry_reg,
    output logic              qry_pending,
    output logic              idle
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] alu_reg_mem  [DEPTH];
    logic [DATA_W-1:0] alu_data_mem [DEPTH];
    logic [ADDR_W-1:0] ld_reg_mem   [DEPTH];
    logic [DATA_W-1:0] ld_data_mem  [DEPTH];

    logic [PTR_W-1:0]  alu_wr_ptr, alu_rd_ptr, ld_wr_ptr, ld_rd_ptr;
    logic [CNT_W-1:0]  alu_cnt, ld_cnt;
    logic              alu_push, ld_push, alu_pop, ld_pop;
    logic              alu_ne, ld_ne;
    logic [ADDR_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data;

    // Ready comes from the count alone, so a full FIFO never refills in the cycle it drains.
    assign alu_ready = (alu_cnt < CNT_W'(DEPTH));
    assign ld_ready  = (ld_cnt  < CNT_W'(DEPTH));
    assign alu_push  = alu_valid && alu_ready;
    assign ld_push   = ld_valid  && ld_ready;
    assign alu_ne    = (alu_cnt != '0);
    assign ld_ne     = (ld_cnt  != '0);
    assign idle      = !alu_ne && !ld_ne && !regWrite;

`ifdef WB_RR_ARB_EN
    typedef enum logic {PRI_ALU = 1'b0, PRI_LD = 1'b1} pri_e;
    pri_e pri_q, pri_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pri_q <= PRI_ALU;
        else        pri_q <= pri_d;
    end

    // Round robin: the pointer moves to the other requester after every grant.
    always_comb begin
        pri_d   = pri_q;
        alu_pop = 1'b0;
        ld_pop  = 1'b0;
        if (alu_ne && (!ld_ne || pri_q == PRI_ALU)) begin
            alu_pop = 1'b1;
            pri_d   = PRI_LD;
        end else if (ld_ne) begin
            ld_pop = 1'b1;
            pri_d  = PRI_ALU;
        end
    end
`else
    always_comb begin
        alu_pop = 1'b0;
        ld_pop  = 1'b0;
        if (ld_ne)       ld_pop  = 1'b1;
        else if (alu_ne) alu_pop = 1'b1;
    end
`endif

    always_comb begin
        head_reg  = ld_reg_mem[ld_rd_ptr];
        head_data = ld_data_mem[ld_rd_ptr];
        if (alu_pop) begin
            head_reg  = alu_reg_mem[alu_rd_ptr];
            head_data = alu_data_mem[alu_rd_ptr];
        end
    end

    // Storage arrays carry no reset; occupancy is defined by the counts.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_reg_mem[alu_wr_ptr]  <= alu_reg;
            alu_data_mem[alu_wr_ptr] <= alu_data;
        end
        if (ld_push) begin
            ld_reg_mem[ld_wr_ptr]  <= ld_reg;
            ld_data_mem[ld_wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_cnt    <= '0;
            ld_wr_ptr  <= '0;
            ld_rd_ptr  <= '0;
            ld_cnt     <= '0;
        end else begin
            if (alu_push) alu_wr_ptr <= alu_wr_ptr + PTR_W'(1);
            if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + PTR_W'(1);
            if (ld_push)  ld_wr_ptr  <= ld_wr_ptr + PTR_W'(1);
            if (ld_pop)   ld_rd_ptr  <= ld_rd_ptr + PTR_W'(1);
            alu_cnt <= alu_cnt + CNT_W'(alu_push) - CNT_W'(alu_pop);
            ld_cnt  <= ld_cnt + CNT_W'(ld_push) - CNT_W'(ld_pop);
        end
    end

    // Register 0 consumes its grant slot but never asserts the write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWrite  <= 1'b0;
            write_reg <= '0;
            writeData <= '0;
        end else begin
            regWrite <= 1'b0;
            if ((alu_pop || ld_pop) && head_reg != '0) begin
                regWrite  <= 1'b1;
                write_reg <= head_reg;
                writeData <= head_data;
            end
        end
    end

    // Hazard query: slot i is occupied when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] alu_off;
        logic [PTR_W-1:0] ld_off;
        qry_pending = regWrite && (write_reg == qry_reg);
        alu_off     = '0;
        ld_off      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            alu_off = PTR_W'(i) - alu_rd_ptr;
            ld_off  = PTR_W'(i) - ld_rd_ptr;
            if (({1'b0, alu_off} < alu_cnt) && (alu_reg_mem[i] == qry_reg)) qry_pending = 1'b1;
            if (({1'b0, ld_off} < ld_cnt) && (ld_reg_mem[i] == qry_reg))    qry_pending = 1'b1;
        end
        if (qry_reg == '0) qry_pending = 1'b0;
    end
endmodule
